// File: rtl/nonce_arb_pkg.sv
// nonce_arb_pkg: shared types and constants for the nonce arbiter slice.
//   NONCE_W     - nonce width in bits
//   CMD_FLUSH   - host command byte that empties the nonce buffer
//   arb_state_t - presentation FSM states (encoding is fixed so that
//                 debug observers can decode o_dbg_state directly)
//   nonce_t     - nonce word in transceiver [0:31] ordering
package nonce_arb_pkg;

  localparam int         NONCE_W   = 32;
  localparam logic [7:0] CMD_FLUSH = 8'hF0;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PRESENT = 2'd1,
    RETIRE  = 2'd2
  } arb_state_t;

  typedef logic [0:NONCE_W-1] nonce_t;

endpackage

// File: rtl/nonce_fifo.sv
// nonce_fifo: small synchronous FIFO holding winning nonces.
//   clk, n_rst - clock, asynchronous active-low reset
//   i_clear    - synchronous flush: pointers and count to zero (wins over push/pop)
//   i_push     - write i_data at the tail (caller guarantees not full)
//   i_data     - nonce to store
//   i_pop      - retire the head entry (caller guarantees not empty)
//   o_head     - head entry, driven from the storage at all times
//   o_count    - current occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module nonce_fifo
  import nonce_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   i_clear,
  input  logic                   i_push,
  input  logic [0:NONCE_W-1]     i_data,
  input  logic                   i_pop,
  output logic [0:NONCE_W-1]     o_head,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [0:NONCE_W-1] r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [AW:0]        r_count;

  // Storage is reset too, so the head reads as zero straight out of reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (i_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/nonce_arbiter.sv
// nonce_arbiter: round-robin arbiter sharing the transceiver nonce return
// path among NUM_CORES hashing cores, with a FIFO_DEPTH-entry nonce buffer
// and a presentation FSM toward the i2c transceiver.
//   clk, n_rst   - clock, asynchronous active-low reset
//   core_req     - per-core request, held with nonce stable until acked
//   core_nonce   - core i nonce at [32*i+31:32*i]
//   core_ack     - one-cycle capture pulse, one-hot or zero
//   nonce_taken  - master finished reading the presented nonce
//   cmd_valid    - command holds a new host command byte
//   command      - host command byte
//   nonce_ready  - head nonce valid toward the transceiver
//   nonce        - head FIFO entry
//   fifo_count   - buffer occupancy
//   o_dbg_state  - presentation FSM state (arb_state_t encoding)
// Optional feature macro: NONCE_ARB_FLUSH_CMD_EN enables the host flush
// command (CMD_FLUSH); without it cmd_valid/command are ignored.
//
// Handshakes: a core presents core_req with a stable nonce and keeps both
// until the cycle core_ack is high, which is the capture cycle; on the
// transceiver side nonce/nonce_ready form a valid that holds until a
// nonce_taken pulse retires it, after which nonce_ready drops for one cycle.
module nonce_arbiter
  import nonce_arb_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES*32-1:0]     core_nonce,
  output logic [NUM_CORES-1:0]        core_ack,
  input  logic                        nonce_taken,
  input  logic                        cmd_valid,
  input  logic [0:7]                  command,
  output logic                        nonce_ready,
  output logic [0:31]                 nonce,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [1:0]                  o_dbg_state
);

  localparam int PW = $clog2(NUM_CORES);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  arb_state_t         r_state;
  arb_state_t         w_state_nxt;
  logic [NUM_CORES-1:0] r_ack;
  logic [PW-1:0]      r_rr_ptr;
  logic [NUM_CORES-1:0] w_elig;
  logic [PW:0]        w_idx;
  logic               w_found;
  logic [PW-1:0]      w_winner;
  logic [0:NONCE_W-1] w_win_nonce;
  logic               w_grant;
  logic               w_pop;
  logic               w_flush;
  logic [CW-1:0]      w_count;
  logic [0:NONCE_W-1] w_head;

`ifdef NONCE_ARB_FLUSH_CMD_EN
  assign w_flush = cmd_valid && (command == CMD_FLUSH);
`else
  logic w_unused_cmd;
  assign w_flush      = 1'b0;
  assign w_unused_cmd = ^{cmd_valid, command};
`endif

  // A core in its ack cycle still shows req high; masking it stops a double capture.
  assign w_elig = core_req & ~r_ack;

  // First eligible index at or after r_rr_ptr, wrapping.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (PW+1)'(k);
      if (w_idx >= (PW+1)'(NUM_CORES)) w_idx = w_idx - (PW+1)'(NUM_CORES);
      if (!w_found && w_elig[w_idx[PW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_idx[PW-1:0];
      end
    end
  end

  always_comb begin
    w_win_nonce = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (w_winner == PW'(i)) w_win_nonce = core_nonce[32*i +: 32];
    end
  end

  // Registered count gates the grant: a pop this edge frees space only for the next edge.
  assign w_grant = w_found && (w_count < CW'(FIFO_DEPTH)) && !w_flush;
  assign w_pop   = (r_state == PRESENT) && nonce_taken && !w_flush;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_ack    <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_ack <= w_grant ? (NUM_CORES'(1) << w_winner) : '0;
      if (w_grant) begin
        r_rr_ptr <= (w_winner == PW'(NUM_CORES-1)) ? '0 : w_winner + PW'(1);
      end
    end
  end

  nonce_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .n_rst   (n_rst),
    .i_clear (w_flush),
    .i_push  (w_grant),
    .i_data  (w_win_nonce),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= EMPTY;
    else        r_state <= w_state_nxt;
  end

  // RETIRE forces one low cycle on nonce_ready so the transceiver sees a new edge.
  always_comb begin
    w_state_nxt = r_state;
    nonce_ready = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_count != '0) w_state_nxt = PRESENT;
      end
      PRESENT: begin
        nonce_ready = 1'b1;
        if (nonce_taken) w_state_nxt = RETIRE;
      end
      RETIRE: begin
        w_state_nxt = (w_count != '0) ? PRESENT : EMPTY;
      end
      default: w_state_nxt = EMPTY;
    endcase
    if (w_flush) w_state_nxt = EMPTY;
  end

  assign core_ack    = r_ack;
  assign nonce       = w_head;
  assign fifo_count  = w_count;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_nonce_arbiter.sv
// tb_nonce_arbiter: directed bench for nonce_arbiter (NUM_CORES=4,
// FIFO_DEPTH=4) with a queue-based reference model and per-cycle compare.
// Honours NONCE_ARB_FLUSH_CMD_EN the same way as the design.
module tb_nonce_arbiter;
  import nonce_arb_pkg::*;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;
`ifdef NONCE_ARB_FLUSH_CMD_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    core_req    = '0;
  logic [N*32-1:0] core_nonce  = '0;
  logic [N-1:0]    core_ack;
  logic            nonce_taken = 1'b0;
  logic            cmd_valid   = 1'b0;
  logic [0:7]      command     = '0;
  logic            nonce_ready;
  logic [0:31]     nonce;
  logic [CW-1:0]   fifo_count;
  logic [1:0]      dbg_state;

  nonce_arbiter #(.NUM_CORES(N), .FIFO_DEPTH(D)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .core_req    (core_req),
    .core_nonce  (core_nonce),
    .core_ack    (core_ack),
    .nonce_taken (nonce_taken),
    .cmd_valid   (cmd_valid),
    .command     (command),
    .nonce_ready (nonce_ready),
    .nonce       (nonce),
    .fifo_count  (fifo_count),
    .o_dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [31:0]  exp_q[$];
  logic [N-1:0] m_ack   = '0;
  bit           m_ready = 1'b0;
  int           m_rr    = 0;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      exp_q.delete();
      m_ack   = '0;
      m_ready = 1'b0;
      m_rr    = 0;
    end else begin
      bit           flush;
      bit           pop;
      bit           grant;
      int           win;
      int           old_size;
      logic [N-1:0] elig;
      flush    = FLUSH_EN && cmd_valid && (command == 8'hF0);
      old_size = exp_q.size();
      pop      = m_ready && nonce_taken && !flush;
      elig     = core_req & ~m_ack;
      grant    = 1'b0;
      win      = 0;
      if (!flush && old_size < D) begin
        for (int k = 0; k < N; k++) begin
          if (!grant && elig[(m_rr + k) % N]) begin
            grant = 1'b1;
            win   = (m_rr + k) % N;
          end
        end
      end
      if (flush) exp_q.delete();
      else begin
        if (pop) void'(exp_q.pop_front());
        if (grant) exp_q.push_back(core_nonce[32*win +: 32]);
      end
      m_ack = '0;
      if (grant) begin
        m_ack[win] = 1'b1;
        m_rr       = (win + 1) % N;
      end
      // Valid next cycle iff something was buffered, nothing retired, no flush.
      m_ready = !flush && !pop && (old_size != 0);
    end
  end

  always @(negedge clk) begin
    chk("ack", 32'(core_ack), 32'(m_ack));
    chk("count", 32'(fifo_count), 32'(exp_q.size()));
    chk("ready", 32'(nonce_ready), 32'(m_ready));
    chk("dbg_state", 32'(dbg_state == 2'(PRESENT)), 32'(m_ready));
    if (m_ready && exp_q.size() > 0) chk("nonce", nonce, exp_q[0]);
  end

  // ---------------- driver tasks ----------------
  int          pend[N];
  logic [31:0] cur[N];

  // One cycle: cores drop/advance their request on ack, then pulses are applied.
  task automatic tick(input bit taken = 1'b0, input bit cv = 1'b0, input logic [7:0] cmd = 8'h00);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (core_ack[i] && pend[i] > 0) begin
        pend[i]--;
        cur[i]++;
      end
    end
    for (int i = 0; i < N; i++) begin
      core_req[i]            = (pend[i] > 0);
      core_nonce[32*i +: 32] = cur[i];
    end
    nonce_taken = taken;
    cmd_valid   = cv;
    command     = cmd;
  endtask

  task automatic do_reset(input bit keep_req);
    @(posedge clk);
    #2;
    n_rst = 1'b0;
    if (!keep_req) begin
      for (int i = 0; i < N; i++) pend[i] = 0;
      core_req = '0;
    end
    nonce_taken = 1'b0;
    cmd_valid   = 1'b0;
    tick();
    chk("rst_ack", 32'(core_ack), 32'h0);
    chk("rst_ready", 32'(nonce_ready), 32'h0);
    chk("rst_count", 32'(fifo_count), 32'h0);
    chk("rst_nonce", nonce, 32'h0);
    n_rst = 1'b1;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 200) begin
      if (nonce_ready) tick(1'b1);
      else             tick();
      guard++;
    end
    tick();
    tick();
    chk("drain_count", 32'(fifo_count), 32'h0);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    for (int i = 0; i < N; i++) begin
      pend[i] = 0;
      cur[i]  = '0;
    end
    do_reset(1'b0);

    // Single request from core 2.
    cur[2] = 32'hDEADBEEF; pend[2] = 1;
    tick();
    tick();
    chk("s1_ack", 32'(core_ack), 32'h4);
    chk("s1_count", 32'(fifo_count), 32'h1);
    chk("s1_ready_lo", 32'(nonce_ready), 32'h0);
    tick();
    chk("s1_ready", 32'(nonce_ready), 32'h1);
    chk("s1_nonce", nonce, 32'hDEADBEEF);
    tick(1'b1);
    tick();
    chk("s1_retire_ready", 32'(nonce_ready), 32'h0);
    chk("s1_retire_count", 32'(fifo_count), 32'h0);
    tick();

    // Round robin from rr_ptr = 0 with all cores requesting.
    do_reset(1'b0);
    for (int i = 0; i < N; i++) begin
      cur[i]  = 32'h1000_0000 * (i + 1);
      pend[i] = 1;
    end
    tick();
    for (int k = 0; k < N; k++) begin
      tick();
      chk("rr_order", 32'(core_ack), 32'(1 << k));
    end
    chk("rr_full", 32'(fifo_count), 32'h4);
    chk("rr_head", nonce, 32'h1000_0000);
    tick(1'b1);
    tick();
    cur[1] = 32'h2222_0001; pend[1] = 1;
    tick();
    tick();
    chk("rr_rereq", 32'(core_ack), 32'h2);
    drain();

    // Full backpressure: five requests into four entries.
    do_reset(1'b0);
    for (int i = 0; i < N; i++) begin
      cur[i]  = 32'hA000_0000 + 32'(i) * 32'h0100_0000;
      pend[i] = (i == 0) ? 2 : 1;
    end
    tick();
    for (int k = 0; k < N; k++) begin
      tick();
      chk("bp_order", 32'(core_ack), 32'(1 << k));
    end
    tick();
    tick();
    chk("bp_held_ack", 32'(core_ack), 32'h0);
    chk("bp_held_count", 32'(fifo_count), 32'h4);
    tick(1'b1);
    tick();
    chk("bp_pop_ack", 32'(core_ack), 32'h0);
    chk("bp_pop_count", 32'(fifo_count), 32'h3);
    tick();
    chk("bp_late_ack", 32'(core_ack), 32'h1);
    chk("bp_late_count", 32'(fifo_count), 32'h4);
    drain();

    // Retire gap with two entries.
    do_reset(1'b0);
    cur[0] = 32'hB000_0000; pend[0] = 1;
    cur[1] = 32'hB100_0000; pend[1] = 1;
    tick();
    tick();
    tick();
    chk("rg_ready", 32'(nonce_ready), 32'h1);
    chk("rg_first", nonce, 32'hB000_0000);
    chk("rg_count", 32'(fifo_count), 32'h2);
    tick(1'b1);
    tick();
    chk("rg_gap", 32'(nonce_ready), 32'h0);
    chk("rg_gap_count", 32'(fifo_count), 32'h1);
    tick();
    chk("rg_second_ready", 32'(nonce_ready), 32'h1);
    chk("rg_second", nonce, 32'hB100_0000);
    tick(1'b1);
    tick();
    chk("rg_last_ready", 32'(nonce_ready), 32'h0);
    chk("rg_last_count", 32'(fifo_count), 32'h0);
    tick();
    chk("rg_empty", 32'(dbg_state), 32'(EMPTY));

    // Simultaneous push and pop at count 2.
    do_reset(1'b0);
    cur[0] = 32'hC000_0000; pend[0] = 1;
    cur[1] = 32'hC100_0000; pend[1] = 1;
    tick();
    tick();
    tick();
    cur[2] = 32'hC200_0000; pend[2] = 1;
    tick(1'b1);
    tick();
    chk("pp_count", 32'(fifo_count), 32'h2);
    chk("pp_ack", 32'(core_ack), 32'h4);
    tick();
    chk("pp_second", nonce, 32'hC100_0000);
    tick(1'b1);
    tick();
    tick();
    chk("pp_third", nonce, 32'hC200_0000);
    drain();

    // Flush command with a pending request (behaviour depends on the macro).
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) begin
      cur[i]  = 32'hD000_0000 + 32'(i);
      pend[i] = 1;
    end
    tick();
    tick();
    tick();
    tick(1'b0, 1'b1, 8'h0F);
    chk("fl_three", 32'(fifo_count), 32'h3);
    cur[3] = 32'hD000_0003; pend[3] = 1;
    tick(1'b0, 1'b1, 8'hF0);
    chk("fl_other_cmd", 32'(fifo_count), 32'h3);
    tick();
    chk("fl_count", 32'(fifo_count), FLUSH_EN ? 32'h0 : 32'h4);
    chk("fl_ready", 32'(nonce_ready), FLUSH_EN ? 32'h0 : 32'h1);
    chk("fl_ack", 32'(core_ack), FLUSH_EN ? 32'h0 : 32'h8);
    tick();
    chk("fl_after_ack", 32'(core_ack), FLUSH_EN ? 32'h8 : 32'h0);
    chk("fl_after_count", 32'(fifo_count), FLUSH_EN ? 32'h1 : 32'h4);

    // Reset mid-operation with a request still held: re-arbitrated afterwards.
    cur[1] = 32'hE100_0000; pend[1] = 1;
    tick();
    do_reset(1'b1);
    tick();
    chk("rst_rearb_ack", 32'(core_ack), 32'h2);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
